pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers: a generic elastic stage buffer that sits between any two CPU pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Replaces the freeze/flush register pair with a valid/ready handshake, a DEPTH-entry circular buffer and a synchronous flush.
- Delivers bubbles with control bits forced to zero.
- Provides occupancy and stall statistics for the hazard unit and for debug.

Parameters:
- CTRL_W, 8, width of the control bundle (WB_en, mem_read, mem_write, branch, S, …); forced to 0 whenever no valid entry is presented.
- DATA_W, 128, width of the data bundle (PC, operand values, instruction, …); not zeroed on bubbles.
- DEPTH, 2, number of buffer entries; legal range 1..16; full throughput requires DEPTH>=2.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush (branch taken).
- in_valid  in  1  upstream stage offers an entry.
- in_ready  out  1  buffer can accept this cycle.
- in_ctrl  in  CTRL_W  control bundle from upstream.
- in_data  in  DATA_W  data bundle from upstream.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head (low = freeze).
- out_ctrl  out  CTRL_W  head control bundle; 0 when out_valid=0.
- out_data  out  DATA_W  head data bundle.
- occupancy  out  clog2(DEPTH+1)  number of stored entries.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:

Reset (rst=0, asynchronous):
- Pointers, occupancy and stall_cnt are 0.
- out_valid=0 and out_ctrl=0.
- The storage array is cleared to 0, so out_data=0.
- in_ready=1 from the first cycle after reset is released.

Handshake:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Both are evaluated at the rising edge.

Ready and valid:
- in_ready = (occupancy < DEPTH) & ~flush.
- in_ready is registered-state-only: there is no combinational path from out_ready or in_valid.
- out_valid = (occupancy != 0).

Ordering and storage:
- Strict FIFO order. Head = entry at the read pointer.
- out_ctrl and out_data are muxed from stored registers; there is no in-to-out combinational path.

Latency and throughput:
- Latency is 1 cycle: an entry pushed at edge N is visible at the outputs after edge N when the buffer was empty.
- DEPTH>=2: 1 entry/cycle sustained with both sides always active.
- DEPTH=1: at most 1 entry every 2 cycles. This is a documented limitation, not a bug.

Simultaneous push and pop:
- Occupancy is unchanged.
- Both pointers advance.

Pointer wrap:
- Pointers wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.

Full:
- in_valid while full is held off by in_ready=0; upstream must hold its data.
- Occupancy never exceeds DEPTH.

Empty:
- out_ready while empty has no effect.
- Occupancy never underflows.

Flush (synchronous, highest priority over push and pop):
- On the edge where flush=1, occupancy and both pointers go to 0.
- Any push or pop in that cycle is discarded.
- in_ready=0 during the flush cycle.
- The next cycle shows out_valid=0 and out_ctrl=0.
- Storage data is not cleared.
- stall_cnt is not affected by flush.

Stall counter:
- Increments by 1 on each edge where out_valid=1 and out_ready=0.
- Saturates at all-ones.
- Cleared only by reset.

Reset mid-operation:
- Immediate return to reset values regardless of clock.
- Buffered entries are lost.

Test Plan:
1. Reset then DEPTH=2 idle: rst low for 3 cycles, then release → in_ready=1, out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0.
2. Streaming: push ctrl=8'hA5 then data 1,2,3,4 on consecutive cycles with out_ready=1 → same values appear in order, one per cycle, 1 cycle after each push; occupancy stays ≤1.
3. Freeze and full: push 3 entries (data 10,11,12) with out_ready=0 at DEPTH=2 → occupancy=2, in_ready=0 and the third entry is held; stall_cnt increments each cycle. Raise out_ready → 10, 11, 12 emerge in order.
4. Flush with simultaneous push and pop: occupancy=2, flush=1 with in_valid=1 and out_ready=1 → next cycle occupancy=0, out_valid=0, out_ctrl=0; the pushed entry never appears.
5. Wrap with DEPTH=3: push and pop 10 entries with random out_ready stalls → output sequence matches input exactly; occupancy in 0..3 throughout.
6. Async reset mid-stream: assert rst between clock edges with occupancy=2 → out_valid, out_ctrl and occupancy are 0 immediately; stall_cnt=0. Set CNT_W=4 and hold a stall for 20 cycles → stall_cnt=15 (saturates).

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: elastic valid/ready stage buffer between CPU pipeline stages.
// DEPTH-entry circular FIFO with synchronous flush, zeroed control on bubbles and stall statistics.
module pipe_stage_buffer #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             stall_cnt
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [CTRL_W-1:0] ctrl_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  count;
    logic              push, pop;

    // explicit wrap keeps non-power-of-two depths inside the array
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == LAST ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_ready  = (count < FULL) & ~flush;
        out_valid = count != '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_ctrl  = out_valid ? ctrl_mem[rd_ptr] : '0;
        out_data  = data_mem[rd_ptr];
        occupancy = count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ctrl_mem[wr_ptr] <= in_ctrl;
                data_mem[wr_ptr] <= in_data;
                wr_ptr           <= nxt(wr_ptr);
            end
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push & ~pop)
                count <= count + 1'b1;
            else if (pop & ~push)
                count <= count - 1'b1;
        end
    end

    // counts frozen cycles even across a flush; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (out_valid & ~out_ready & ~&stall_cnt)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: scoreboard bench for two pipe_stage_buffer configurations.
// Instance 0 is DEPTH=2/CNT_W=16, instance 1 is DEPTH=3/CNT_W=4.
module tb_pipe_stage_buffer;
    logic         clk = 0;
    logic         rst = 0;
    logic         flush [2];
    logic         in_valid [2];
    logic         out_ready [2];
    logic [7:0]   in_ctrl [2];
    logic [127:0] in_data [2];
    logic         ir [2];
    logic         ov [2];
    logic [7:0]   oc [2];
    logic [127:0] od [2];
    logic [1:0]   occ [2];
    logic [15:0]  sc [2];
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D  = g == 0 ? 2 : 3;
        localparam int CW = g == 0 ? 16 : 4;
        logic [CW-1:0]  sc_w;
        logic [135:0]   q [$];
        int             mst = 0;
        int             popped = 0;
        logic           acc = 0;
        logic           exp_ready, exp_valid;
        assign sc[g] = 16'(sc_w);
        pipe_stage_buffer #(.CTRL_W(8), .DATA_W(128), .DEPTH(D), .CNT_W(CW)) dut (
            .clk(clk), .rst(rst), .flush(flush[g]),
            .in_valid(in_valid[g]), .in_ready(ir[g]), .in_ctrl(in_ctrl[g]), .in_data(in_data[g]),
            .out_valid(ov[g]), .out_ready(out_ready[g]), .out_ctrl(oc[g]), .out_data(od[g]),
            .occupancy(occ[g]), .stall_cnt(sc_w)
        );
        // check outputs against the model, then predict the coming rising edge
        always @(negedge clk) begin
            if (!rst) begin
                q.delete();
                mst = 0;
            end
            exp_ready = (q.size() < D) && !flush[g];
            exp_valid = q.size() != 0;
            chk("in_ready", g, 128'(ir[g]), 128'(exp_ready));
            chk("out_valid", g, 128'(ov[g]), 128'(exp_valid));
            chk("occupancy", g, 128'(occ[g]), 128'(q.size()));
            chk("stall_cnt", g, 128'(sc[g]), 128'(mst));
            if (exp_valid) begin
                chk("out_ctrl", g, 128'(oc[g]), 128'(q[0][135:128]));
                chk("out_data", g, od[g], q[0][127:0]);
            end else
                chk("bubble_ctrl", g, 128'(oc[g]), 128'(0));
            acc = rst && in_valid[g] && exp_ready;
            if (rst) begin
                if (exp_valid && !out_ready[g] && mst != (1 << CW) - 1)
                    mst++;
                if (flush[g])
                    q.delete();
                else begin
                    if (exp_valid && out_ready[g]) begin
                        void'(q.pop_front());
                        popped++;
                    end
                    if (acc)
                        q.push_back({in_ctrl[g], in_data[g]});
                end
            end
        end
    end

    task automatic drive(input int g, input logic f, input logic v, input logic [7:0] c,
                         input logic [127:0] d, input logic r);
        flush[g]     = f;
        in_valid[g]  = v;
        in_ctrl[g]   = c;
        in_data[g]   = d;
        out_ready[g] = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, cyc;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 0; in_valid[i] = 0; out_ready[i] = 0; in_ctrl[i] = 0; in_data[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1;
        chk("rst_in_ready", 0, 128'(ir[0]), 128'(1));
        chk("rst_out_data", 0, od[0], 128'(0));
        // streaming at full rate
        for (int i = 1; i <= 4; i++)
            drive(0, 0, 1, 8'hA5, 128'(i), 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        // freeze until full, third entry held off
        drive(0, 0, 1, 8'h3C, 128'd10, 0);
        drive(0, 0, 1, 8'h3C, 128'd11, 0);
        chk("full_occ", 0, 128'(occ[0]), 128'(2));
        chk("full_ready", 0, 128'(ir[0]), 128'(0));
        repeat (3) drive(0, 0, 1, 8'h3C, 128'd12, 0);
        drive(0, 0, 1, 8'h3C, 128'd12, 1);
        drive(0, 0, 1, 8'h3C, 128'd12, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        // flush with simultaneous push and pop
        drive(0, 0, 1, 8'h11, 128'd20, 0);
        drive(0, 0, 1, 8'h22, 128'd21, 0);
        drive(0, 1, 1, 8'h33, 128'd22, 1);
        chk("flush_valid", 0, 128'(ov[0]), 128'(0));
        chk("flush_occ", 0, 128'(occ[0]), 128'(0));
        chk("flush_ctrl", 0, 128'(oc[0]), 128'(0));
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        // DEPTH=3 wrap with random downstream stalls
        sent = 0;
        cyc = 0;
        while (g_dut[1].popped < 10 && cyc < 300) begin
            drive(1, 0, sent < 10, 8'(sent + 1), 128'(100 + sent), 1'($urandom_range(0, 1)));
            if (g_dut[1].acc) sent++;
            cyc++;
            if (occ[1] > 3) chk("wrap_occ_range", 1, 128'(occ[1]), 128'(3));
        end
        chk("wrap_popped", 1, 128'(g_dut[1].popped), 128'(10));
        drive(1, 0, 0, 0, 0, 0);
        // asynchronous reset between clock edges
        drive(0, 0, 1, 8'h44, 128'd30, 0);
        drive(0, 0, 1, 8'h55, 128'd31, 0);
        in_valid[0] = 0;
        #2 rst = 0;
        #1;
        chk("arst_valid", 0, 128'(ov[0]), 128'(0));
        chk("arst_ctrl", 0, 128'(oc[0]), 128'(0));
        chk("arst_occ", 0, 128'(occ[0]), 128'(0));
        chk("arst_stall", 0, 128'(sc[0]), 128'(0));
        @(posedge clk);
        #1 rst = 1;
        // saturation of a 4-bit stall counter
        drive(1, 0, 1, 8'h66, 128'd55, 0);
        repeat (20) drive(1, 0, 0, 0, 0, 0);
        chk("stall_sat", 1, 128'(sc[1]), 128'(15));
        repeat (2) drive(1, 0, 0, 0, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
